// File: rtl/kpd_pkg.sv
// kpd_pkg: FSM state type, keypad geometry and code decode helpers for the keypad emulator.
//   state_t     : emulator phase (IDLE, press bounce, hold, release bounce, gap)
//   ROW_*       : active-low one-hot row patterns driven by the scanner
//   key_map()   : key code -> {row, active-low column}; invalid codes give {3'b111, 4'hF}
//   code_valid(): codes 0-9, a, b are keys; c-f are rejected
package kpd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PB, S_HOLD, S_RB, S_GAP} state_t;
  localparam logic [2:0] ROW_123A = 3'b110;
  localparam logic [2:0] ROW_456B = 3'b101;
  localparam logic [2:0] ROW_7890 = 3'b011;
  localparam logic [2:0] ROW_NONE = 3'b111;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef struct packed {
    logic [2:0] row;
    logic [3:0] col;
  } key_pos_t;
  function automatic logic code_valid(input logic [3:0] code);
    return code <= 4'hb;
  endfunction
  function automatic key_pos_t key_map(input logic [3:0] code);
    key_pos_t p;
    p = '{ROW_NONE, 4'hF};
    case (code)
      4'h1: p = '{ROW_123A, 4'b1110};
      4'h2: p = '{ROW_123A, 4'b1101};
      4'h3: p = '{ROW_123A, 4'b1011};
      4'ha: p = '{ROW_123A, 4'b0111};
      4'h4: p = '{ROW_456B, 4'b1110};
      4'h5: p = '{ROW_456B, 4'b1101};
      4'h6: p = '{ROW_456B, 4'b1011};
      4'hb: p = '{ROW_456B, 4'b0111};
      4'h7: p = '{ROW_7890, 4'b1110};
      4'h8: p = '{ROW_7890, 4'b1101};
      4'h9: p = '{ROW_7890, 4'b1011};
      4'h0: p = '{ROW_7890, 4'b0111};
      default: p = '{ROW_NONE, 4'hF};
    endcase
    return p;
  endfunction
endpackage

// File: rtl/kpd_emulator_if.sv
// kpd_emulator_if: valid/ready key request channel into the keypad emulator.
//   KEY_valid : source -> emulator, request present (held until accepted)
//   KEY_ready : emulator -> source, emulator idle and able to accept
//   KEY_code  : source -> emulator, key value 0-9, a, b
//   KEY_hold  : source -> emulator, stable-closed duration in cycles
interface kpd_emulator_if #(parameter int HOLD_W = 24);
  logic              KEY_valid;
  logic              KEY_ready;
  logic [3:0]        KEY_code;
  logic [HOLD_W-1:0] KEY_hold;
  modport master (output KEY_valid, output KEY_code, output KEY_hold, input KEY_ready);
  modport slave (input KEY_valid, input KEY_code, input KEY_hold, output KEY_ready);
endinterface

// File: rtl/kpd_lfsr16.sv
// kpd_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as contact chatter source.
//   i_clk   : clock, advances every rising edge
//   i_rst_n : asynchronous active-low reset to the seed 16'hACE1
//   o_bit0  : current state bit 0
module kpd_lfsr16
  import kpd_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_bit0
);
  logic [15:0] r_state;
  logic        w_fb;
  // Right-shifting form: taps 16,14,13,11 map to bits 0,2,3,5; a nonzero seed never reaches zero.
  assign w_fb = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= LFSR_SEED;
    else r_state <= {w_fb, r_state[15:1]};
  assign o_bit0 = r_state[0];
endmodule

// File: rtl/kpd_emulator.sv
// kpd_emulator: emulates one key of a 3x4 matrix keypad pressed with chatter, held, released with chatter.
//   CLK_50M  : sole clock
//   RST_N    : asynchronous active-low reset
//   key      : valid/ready request channel (code, hold length)
//   KPD_R    : row drive from the scanner, active-low one-hot
//   KPD_C    : column sense, active-low, 4'hF when open
//   EMU_busy : high whenever not idle
//   EMU_done : one-cycle pulse on the last gap cycle
//   EMU_err  : one-cycle pulse the cycle after an invalid code is accepted
module kpd_emulator
  import kpd_pkg::*;
#(
  parameter int BOUNCE_CYC = 50000,
  parameter int GAP_CYC    = 2100000,
  parameter int HOLD_W     = 24
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  kpd_emulator_if.slave key,
  input  logic [2:0] KPD_R,
  output logic [3:0] KPD_C,
  output logic       EMU_busy,
  output logic       EMU_done,
  output logic       EMU_err
);
  localparam longint H_MAX = (longint'(1) << HOLD_W) - 1;
  localparam longint BG_MAX = (longint'(BOUNCE_CYC) > longint'(GAP_CYC)) ? longint'(BOUNCE_CYC) : longint'(GAP_CYC);
  localparam longint C_MAX = (BG_MAX > H_MAX) ? BG_MAX : H_MAX;
  localparam int CW = $clog2(C_MAX + 1);
  // Counters hold "cycles remaining minus one" so a phase ends when the count reaches zero.
  localparam logic [CW-1:0] W_BNC = CW'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
  localparam logic [CW-1:0] W_GAP = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam bit HAS_BNC = BOUNCE_CYC > 0;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_code;
  logic [HOLD_W-1:0] r_hold;
  logic              r_run;
  logic              r_err;
  logic              w_ready;
  logic              w_xfer;
  logic              w_chatter;
  logic              w_contact;
  logic [HOLD_W-1:0] w_hold_src;
  logic [CW-1:0]     w_hold_ld;
  key_pos_t          w_pos;
  kpd_lfsr16 u_lfsr (
    .i_clk   (CLK_50M),
    .i_rst_n (RST_N),
    .o_bit0  (w_chatter)
  );
  // r_run keeps KEY_ready low while reset is asserted even though the state reads IDLE.
  assign w_ready = r_run && (r_state == S_IDLE);
  assign w_xfer = key.KEY_valid && w_ready;
  // With no press bounce the hold count is loaded straight from the request at transfer.
  assign w_hold_src = (r_state == S_IDLE) ? key.KEY_hold : r_hold;
  assign w_hold_ld = (w_hold_src == '0) ? '0 : CW'(w_hold_src) - CW'(1);
  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
      r_hold  <= '0;
      r_run   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE:
          if (w_xfer) begin
            r_code <= key.KEY_code;
            r_hold <= key.KEY_hold;
            if (!code_valid(key.KEY_code)) r_err <= 1'b1;
            else begin
              r_state <= HAS_BNC ? S_PB : S_HOLD;
              r_cnt   <= HAS_BNC ? W_BNC : w_hold_ld;
            end
          end
        S_PB:
          if (r_cnt == '0) begin
            r_state <= S_HOLD;
            r_cnt   <= w_hold_ld;
          end else r_cnt <= r_cnt - CW'(1);
        S_HOLD:
          if (r_cnt == '0) begin
            r_state <= HAS_BNC ? S_RB : S_GAP;
            r_cnt   <= HAS_BNC ? W_BNC : W_GAP;
          end else r_cnt <= r_cnt - CW'(1);
        S_RB:
          if (r_cnt == '0) begin
            r_state <= S_GAP;
            r_cnt   <= W_GAP;
          end else r_cnt <= r_cnt - CW'(1);
        S_GAP:
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else r_cnt <= r_cnt - CW'(1);
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  assign w_pos = key_map(r_code);
  assign w_contact = (r_state == S_HOLD) || (((r_state == S_PB) || (r_state == S_RB)) && w_chatter);
  // The column follows the scanner's row drive combinationally, as a real switch contact would.
  assign KPD_C = (w_contact && (KPD_R == w_pos.row)) ? w_pos.col : 4'hF;
  assign key.KEY_ready = w_ready;
  assign EMU_busy = r_state != S_IDLE;
  assign EMU_done = (r_state == S_GAP) && (r_cnt == '0);
  assign EMU_err = r_err;
endmodule

// File: tb/tb_kpd_emulator.sv
// tb_kpd_emulator: directed vector and sequence bench for kpd_emulator with BOUNCE_CYC=8, GAP_CYC=16.
module tb_kpd_emulator;
  logic       CLK_50M = 1'b0;
  logic       RST_N;
  logic [2:0] KPD_R;
  logic [3:0] KPD_C;
  logic       EMU_busy, EMU_done, EMU_err;
  logic       auto_mode = 1'b1;
  logic [2:0] kpd_r_man = 3'b111;
  int         idx = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  kpd_emulator_if #(.HOLD_W(24)) kif ();
  kpd_emulator #(.BOUNCE_CYC(8), .GAP_CYC(16), .HOLD_W(24)) dut (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .key      (kif.slave),
    .KPD_R    (KPD_R),
    .KPD_C    (KPD_C),
    .EMU_busy (EMU_busy),
    .EMU_done (EMU_done),
    .EMU_err  (EMU_err)
  );
  always #10 CLK_50M = ~CLK_50M;
  always @(posedge CLK_50M) idx <= (idx == 2) ? 0 : idx + 1;
  assign KPD_R = auto_mode ? ((idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011) : kpd_r_man;

  typedef struct {
    logic [3:0] code;
    logic [2:0] row;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[19];

  // Simple scanner: accumulates one 3-row scan, debounces press over 6 scans and release over 4.
  logic       scan_en = 1'b0;
  logic       sc_acc = 1'b0;
  logic       sc_pressed = 1'b0;
  logic [3:0] sc_code = 4'hF;
  int         sc_cl = 0;
  int         sc_op = 0;
  int         n_press = 0;
  int         n_rel = 0;
  logic [3:0] pressq[$];

  function automatic logic [3:0] dec(input logic [2:0] r, input logic [3:0] c);
    case ({r, c})
      7'b110_1110: return 4'h1;
      7'b110_1101: return 4'h2;
      7'b110_1011: return 4'h3;
      7'b110_0111: return 4'ha;
      7'b101_1110: return 4'h4;
      7'b101_1101: return 4'h5;
      7'b101_1011: return 4'h6;
      7'b101_0111: return 4'hb;
      7'b011_1110: return 4'h7;
      7'b011_1101: return 4'h8;
      7'b011_1011: return 4'h9;
      7'b011_0111: return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  always @(negedge CLK_50M)
    if (scan_en) begin
      if (KPD_C != 4'hF) begin
        sc_acc = 1'b1;
        sc_code = dec(KPD_R, KPD_C);
      end
      if (KPD_R == 3'b011) begin
        if (sc_acc) begin
          sc_op = 0;
          sc_cl++;
          if (!sc_pressed && sc_cl >= 6) begin
            sc_pressed = 1'b1;
            n_press++;
            pressq.push_back(sc_code);
          end
        end else begin
          sc_cl = 0;
          sc_op++;
          if (sc_pressed && sc_op >= 4) begin
            sc_pressed = 1'b0;
            n_rel++;
          end
        end
        sc_acc = 1'b0;
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic accept(input string name);
    logic r;
    int k;
    k = 0;
    do begin
      r = kif.KEY_ready;
      step();
      k++;
    end while (!r && k < 1000);
    chk({name, " accepted"}, 32'(r), 1);
  endtask

  task automatic send(input logic [3:0] code, input logic [23:0] hold, input string name);
    kif.KEY_valid = 1'b1;
    kif.KEY_code = code;
    kif.KEY_hold = hold;
    accept(name);
    kif.KEY_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!kif.KEY_ready && k < 1000) begin
      step();
      k++;
    end
    chk({name, " idle"}, 32'(kif.KEY_ready), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int errs, dn, first, rdy_n, c1, c2;
    logic [3:0] col;
    logic [3:0] ck[5];
    ck = '{4'h3, 4'h7, 4'hb, 4'h0, 4'ha};
    vecs[0]  = '{4'h1, 3'b110, 4'b1110};
    vecs[1]  = '{4'h2, 3'b110, 4'b1101};
    vecs[2]  = '{4'h3, 3'b110, 4'b1011};
    vecs[3]  = '{4'ha, 3'b110, 4'b0111};
    vecs[4]  = '{4'h4, 3'b101, 4'b1110};
    vecs[5]  = '{4'h5, 3'b101, 4'b1101};
    vecs[6]  = '{4'h6, 3'b101, 4'b1011};
    vecs[7]  = '{4'hb, 3'b101, 4'b0111};
    vecs[8]  = '{4'h7, 3'b011, 4'b1110};
    vecs[9]  = '{4'h8, 3'b011, 4'b1101};
    vecs[10] = '{4'h9, 3'b011, 4'b1011};
    vecs[11] = '{4'h0, 3'b011, 4'b0111};
    vecs[12] = '{4'h5, 3'b110, 4'hF};
    vecs[13] = '{4'h5, 3'b011, 4'hF};
    vecs[14] = '{4'h5, 3'b000, 4'hF};
    vecs[15] = '{4'h5, 3'b111, 4'hF};
    vecs[16] = '{4'h0, 3'b010, 4'hF};
    vecs[17] = '{4'h1, 3'b100, 4'hF};
    vecs[18] = '{4'hb, 3'b001, 4'hF};
    kif.KEY_valid = 1'b0;
    kif.KEY_code = 4'h0;
    kif.KEY_hold = 24'd0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #4;
    chk("rst ready", 32'(kif.KEY_ready), 0);
    chk("rst kpd_c", 32'(KPD_C), 32'hF);
    chk("rst busy/done/err", {29'd0, EMU_busy, EMU_done, EMU_err}, 0);
    @(posedge CLK_50M);
    @(posedge CLK_50M);
    #5 RST_N = 1'b1;
    step();
    chk("post-rst ready", 32'(kif.KEY_ready), 1);

    // Code 5, hold 100: column 1101 only on row 101 during hold, done on cycle 131 after transfer.
    send(4'h5, 24'd100, "k5");
    errs = 0; dn = 0; first = -1;
    chk("k5 busy", 32'(EMU_busy), 1);
    chk("k5 ready low while busy", 32'(kif.KEY_ready), 0);
    for (int n = 0; n < 140; n++) begin
      col = (KPD_R == 3'b101) ? 4'b1101 : 4'hF;
      if (n >= 8 && n < 108) begin
        if (KPD_C !== col) errs++;
      end else if (n < 116) begin
        if (KPD_C !== 4'hF && KPD_C !== col) errs++;
      end else if (KPD_C !== 4'hF) errs++;
      if (EMU_done) begin
        dn++;
        if (first < 0) first = n;
      end
      step();
    end
    chk("k5 column errors", 32'(errs), 0);
    chk("k5 done count", 32'(dn), 1);
    chk("k5 done cycle", 32'(first), 131);
    chk("k5 idle ready", 32'(kif.KEY_ready), 1);
    chk("k5 idle busy", 32'(EMU_busy), 0);

    // Invalid code c: error pulse only, no closure, stays ready.
    send(4'hc, 24'd50, "kc");
    chk("kc err pulse", 32'(EMU_err), 1);
    chk("kc ready", 32'(kif.KEY_ready), 1);
    chk("kc busy", 32'(EMU_busy), 0);
    errs = 0; dn = 0; c1 = 0;
    for (int n = 0; n < 40; n++) begin
      if (KPD_C !== 4'hF) errs++;
      if (EMU_done) dn++;
      step();
      if (EMU_err) c1++;
    end
    chk("kc kpd_c", 32'(errs), 0);
    chk("kc done", 32'(dn), 0);
    chk("kc err single", 32'(c1), 0);

    // Code 0, hold 0: single hold cycle, done on cycle 32.
    auto_mode = 1'b0;
    kpd_r_man = 3'b011;
    send(4'h0, 24'd0, "k0");
    dn = 0; first = -1;
    for (int n = 0; n < 40; n++) begin
      if (n == 8) chk("k0 hold col", 32'(KPD_C), 32'b0111);
      if (EMU_done) begin
        dn++;
        if (first < 0) first = n;
      end
      step();
    end
    chk("k0 done cycle", 32'(first), 32);
    chk("k0 done count", 32'(dn), 1);

    // Column mapping table, applied during hold with the row forced.
    foreach (vecs[i]) begin
      kpd_r_man = 3'b111;
      send(vecs[i].code, 24'd20, $sformatf("vec%0d", i));
      repeat (12) step();
      kpd_r_man = vecs[i].row;
      #1;
      chk($sformatf("vec%0d code %0h row %b", i, vecs[i].code, vecs[i].row), 32'(KPD_C), 32'(vecs[i].exp));
      wait_idle($sformatf("vec%0d", i));
    end

    // Reset during hold of code a: contact opens at once, no done afterwards.
    kpd_r_man = 3'b110;
    send(4'ha, 24'd100, "ka");
    repeat (20) step();
    chk("ka hold col", 32'(KPD_C), 32'b0111);
    #3 RST_N = 1'b0;
    #1;
    chk("ka rst kpd_c", 32'(KPD_C), 32'hF);
    chk("ka rst busy", 32'(EMU_busy), 0);
    chk("ka rst ready", 32'(kif.KEY_ready), 0);
    step();
    step();
    #2 RST_N = 1'b1;
    dn = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (EMU_done) dn++;
    end
    chk("ka no done", 32'(dn), 0);
    chk("ka ready after rst", 32'(kif.KEY_ready), 1);

    // Back-to-back codes 1 then b with KEY_valid held.
    auto_mode = 1'b1;
    kif.KEY_valid = 1'b1;
    kif.KEY_code = 4'h1;
    kif.KEY_hold = 24'd30;
    accept("b2b first");
    kif.KEY_code = 4'hb;
    errs = 0; dn = 0; first = -1; rdy_n = -1; c1 = 0; c2 = 0;
    for (int n = 0; n < 140; n++) begin
      if (KPD_C !== 4'hF) begin
        if (n < 63) begin
          if (KPD_R === 3'b110 && KPD_C === 4'b1110) c1++; else errs++;
        end else begin
          if (KPD_R === 3'b101 && KPD_C === 4'b0111) c2++; else errs++;
        end
      end
      if (EMU_done) begin
        dn++;
        if (first < 0) first = n;
      end
      if (kif.KEY_ready && rdy_n < 0) rdy_n = n;
      step();
      if (rdy_n >= 0) kif.KEY_valid = 1'b0;
    end
    chk("b2b first done cycle", 32'(first), 61);
    chk("b2b second accept cycle", 32'(rdy_n), 62);
    chk("b2b done count", 32'(dn), 2);
    chk("b2b wrong closures", 32'(errs), 0);
    chk("b2b key1 closures seen", 32'(c1 > 0), 1);
    chk("b2b keyb closures seen", 32'(c2 > 0), 1);

    // Closed loop with the scanner model: one press and one release per key.
    wait_idle("scan pre");
    scan_en = 1'b1;
    foreach (ck[i]) begin
      kif.KEY_valid = 1'b1;
      kif.KEY_code = ck[i];
      kif.KEY_hold = 24'd60;
      accept($sformatf("scan key%0d", i));
    end
    kif.KEY_valid = 1'b0;
    wait_idle("scan post");
    repeat (30) step();
    scan_en = 1'b0;
    chk("scan presses", 32'(n_press), 5);
    chk("scan releases", 32'(n_rel), 5);
    chk("scan queue size", 32'(pressq.size()), 5);
    for (int i = 0; i < 5 && i < pressq.size(); i++)
      chk($sformatf("scan code%0d", i), 32'(pressq[i]), 32'(ck[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/kpd_emulator.md
KPD_EMULATOR -- requirements
Module: kpd_emulator

Interface
REQ-001 SHALL have parameter BOUNCE_CYC, default 50000, meaning cycles of contact chatter on press and on release.
REQ-002 SHALL have parameter GAP_CYC, default 2100000, meaning cycles of forced open contact after release before next key.
REQ-003 SHALL have parameter HOLD_W, default 24, meaning width of KEY_hold.
REQ-004 SHALL have port CLK_50M  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port KEY_valid  in  1  key request valid.
REQ-007 SHALL have port KEY_ready  out  1  emulator accepts request.
REQ-008 SHALL have port KEY_code  in  4  key value 0-9, a, b.
REQ-009 SHALL have port KEY_hold  in  HOLD_W  stable-closed duration in cycles.
REQ-010 SHALL have port KPD_R  in  3  row drive from scanner, active-low one-hot.
REQ-011 SHALL have port KPD_C  out  4  column sense, active-low, idle 4'hF.
REQ-012 SHALL have port EMU_busy  out  1  high whenever not IDLE.
REQ-013 SHALL have port EMU_done  out  1  one-cycle pulse at end of GAP.
REQ-014 SHALL have port EMU_err  out  1  one-cycle pulse on invalid code.

Function
REQ-015 SHALL map codes: row 3'b110 -> 1,2,3,a on cols 1110,1101,1011,0111; row 3'b101 -> 4,5,6,b; row 3'b011 -> 7,8,9,0, same column order.
REQ-016 SHALL drive KPD_C combinationally: key column low only when contact closed and KPD_R equals key row; else 4'hF (any other KPD_R, incl. non-one-hot, gives 4'hF).
REQ-017 SHALL use FSM IDLE -> PB (press bounce) -> HOLD -> RB (release bounce) -> GAP -> IDLE.
REQ-018 SHALL assert KEY_ready only in IDLE; transfer on KEY_valid & KEY_ready; KEY_code and KEY_hold latched at transfer.
REQ-019 SHALL on invalid code (c-f): stay IDLE, pulse EMU_err the next cycle, no contact closure, no EMU_done.
REQ-020 SHALL in PB and RB drive contact = LFSR bit0 for exactly BOUNCE_CYC cycles each; BOUNCE_CYC=0 skips the state.
REQ-021 SHALL in HOLD keep contact closed for exactly max(KEY_hold,1) cycles.
REQ-022 SHALL in GAP keep contact open for exactly GAP_CYC cycles, pulse EMU_done on the last GAP cycle, enter IDLE next cycle.
REQ-023 SHALL use 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing every cycle, never all-zero.
REQ-024 SHALL size counters to the largest of BOUNCE_CYC, GAP_CYC, 2^HOLD_W-1; no wrap within a phase.
REQ-025 SHALL accept the next request in the first IDLE cycle after GAP (back-to-back keys allowed).
REQ-026 SHALL ignore KEY_valid while busy; request held by source until accepted.

Reset
REQ-027 SHALL on RST_N low, asynchronously: state IDLE, contact open (KPD_C=4'hF), counters 0, LFSR 16'hACE1, KEY_ready 0 during reset then 1, EMU_busy/EMU_done/EMU_err 0.
REQ-028 SHALL on reset mid-press abort with contact open immediately; no EMU_done.

Structure
REQ-029 SHALL place in package kpd_pkg: state enum, row constants 3'b110/3'b101/3'b011, code-to-row/column mapping function, code-valid function.
REQ-030 SHALL instantiate one sub-module kpd_lfsr16 (clock, async reset, 16-bit state, bit0 out).

Verification (BOUNCE_CYC=8, GAP_CYC=16, KPD_R cycled 110/101/011)
REQ-031 SHALL cover: code 4'h5, hold 100 -> KPD_C=4'b1101 only while KPD_R=3'b101 for 100 HOLD cycles; EMU_done 1 pulse after 8+100+8+16 cycles.
REQ-032 SHALL cover: code 4'hc -> EMU_err one pulse, KPD_C stays 4'hF, KEY_ready high again next cycle.
REQ-033 SHALL cover: code 4'h0, hold 0 -> exactly 1 HOLD cycle, col 0111 on row 3'b011.
REQ-034 SHALL cover: RST_N low during HOLD of code 4'ha -> KPD_C=4'hF same cycle, no EMU_done, KEY_ready 1 after release.
REQ-035 SHALL cover: codes 1 then b, KEY_valid held -> second accepted cycle after first EMU_done; KPD_C 1110 on row 110, then 0111 on row 101.
REQ-036 SHALL cover: closed-loop with keypad scanner, 1 ms bounce -> scanner reports exactly one press and one release per key, value matches code.
